// File: rtl/dma_utils_pkg.sv
// rtl/dma_utils_pkg.sv - shared types and defaults for the multi-channel DMA scheduler
package dma_utils_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_NUM_DESC = 2;

    typedef enum logic [1:0] {CH_IDLE, CH_PEND, CH_DONE, CH_ERR} ch_state_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} sched_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_mch_sched_if.sv
// rtl/dma_mch_sched_if.sv - job handshake between the scheduler and the streamer pair
interface dma_mch_sched_if #(
    parameter int NUM_CH  = dma_utils_pkg::DEF_NUM_CH,
    parameter int ADDR_W  = 32,
    parameter int BYTES_W = 32
);
    localparam int CH_W = dma_utils_pkg::clog2_min1(NUM_CH);

    logic               sched_valid_o;
    logic               sched_ready_i;
    logic [CH_W-1:0]    sched_ch_o;
    logic [ADDR_W-1:0]  sched_src_o;
    logic [ADDR_W-1:0]  sched_dst_o;
    logic [BYTES_W-1:0] sched_bytes_o;
    logic               job_done_i;
    logic               job_err_i;
    logic               job_abort_o;

    modport master (
        output sched_valid_o, sched_ch_o, sched_src_o, sched_dst_o, sched_bytes_o, job_abort_o,
        input  sched_ready_i, job_done_i, job_err_i
    );

    modport slave (
        input  sched_valid_o, sched_ch_o, sched_src_o, sched_dst_o, sched_bytes_o, job_abort_o,
        output sched_ready_i, job_done_i, job_err_i
    );

endinterface

// File: rtl/dma_rr_arbiter.sv
// rtl/dma_rr_arbiter.sv - round-robin arbiter, priority starts just after the last accepted grantee
module dma_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_accept,
    output logic [N-1:0] o_grant
);
    localparam int PW = dma_utils_pkg::clog2_min1(N);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;

    // Scan from the farthest distance down so the requester nearest the pointer is written last.
    always_comb begin
        o_grant    = '0;
        w_next_ptr = r_ptr;
        for (int d = N - 1; d >= 0; d--) begin
            for (int j = 0; j < N; j++) begin
                if (i_req[j] && (((j - int'(r_ptr)) + N) % N) == d) begin
                    o_grant    = '0;
                    o_grant[j] = 1'b1;
                    w_next_ptr = PW'((j + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/dma_mch_sched.sv
// rtl/dma_mch_sched.sv - multi-channel DMA descriptor scheduler, one job in flight at a time
module dma_mch_sched
    import dma_utils_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int NUM_DESC = DEF_NUM_DESC,
    parameter int ADDR_W   = 32,
    parameter int BYTES_W  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   ch_go_i,
    input  logic [NUM_CH-1:0]                   ch_abort_i,
    input  logic [NUM_CH-1:0]                   ch_clear_i,
    input  logic [NUM_CH*NUM_DESC-1:0]          desc_en_i,
    input  logic [NUM_CH*NUM_DESC*ADDR_W-1:0]   desc_src_i,
    input  logic [NUM_CH*NUM_DESC*ADDR_W-1:0]   desc_dst_i,
    input  logic [NUM_CH*NUM_DESC*BYTES_W-1:0]  desc_bytes_i,
    output logic [NUM_CH-1:0]                   ch_busy_o,
    output logic [NUM_CH-1:0]                   ch_done_o,
    output logic [NUM_CH-1:0]                   ch_err_o,
    dma_mch_sched_if.master                     sif
);
    localparam int CH_W = clog2_min1(NUM_CH);
    localparam int DI_W = $clog2(NUM_DESC + 1);

    ch_state_t          r_ch_st [NUM_CH];
    logic [DI_W-1:0]    r_didx  [NUM_CH];
    sched_state_t       r_st;
    logic [CH_W-1:0]    r_run;
    logic [NUM_CH-1:0]  r_req;
    logic               r_valid;
    logic               r_abort;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [BYTES_W-1:0] r_bytes;

    logic [NUM_CH-1:0]  w_pend, w_running, w_has_more, w_arb_req, w_grant;
    logic               w_found, w_accept, w_run_abort, w_run_more;
    logic [CH_W-1:0]    w_gch;
    logic [DI_W-1:0]    w_dnext;
    logic [ADDR_W-1:0]  w_src, w_dst;
    logic [BYTES_W-1:0] w_bytes;

    always_comb begin
        w_pend    = '0;
        w_running = '0;
        ch_busy_o = '0;
        ch_done_o = '0;
        ch_err_o  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pend[c]    = (r_ch_st[c] == CH_PEND);
            w_running[c] = (r_st != S_IDLE) && (int'(r_run) == c);
            ch_busy_o[c] = (r_ch_st[c] == CH_PEND);
            ch_done_o[c] = (r_ch_st[c] == CH_DONE);
            ch_err_o[c]  = (r_ch_st[c] == CH_ERR);
        end
    end

    // r_req lags w_pend by a cycle, giving a fresh go one cycle of settling before arbitration.
    assign w_arb_req = r_req & w_pend & ~ch_abort_i;
    assign w_accept  = (r_st == S_IDLE) && (|w_grant);

    dma_rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_arb_req),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Lowest remaining usable descriptor of the granted channel; k descends so the lowest is written last.
    always_comb begin
        w_has_more = '0;
        w_found    = 1'b0;
        w_gch      = '0;
        w_dnext    = '0;
        w_src      = '0;
        w_dst      = '0;
        w_bytes    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant[c]) w_gch = CH_W'(c);
            for (int k = NUM_DESC - 1; k >= 0; k--) begin
                if (k >= int'(r_didx[c]) && desc_en_i[c*NUM_DESC+k] &&
                    desc_bytes_i[(c*NUM_DESC+k)*BYTES_W +: BYTES_W] != '0) begin
                    w_has_more[c] = 1'b1;
                    if (w_grant[c]) begin
                        w_found = 1'b1;
                        w_dnext = DI_W'(k + 1);
                        w_src   = desc_src_i[(c*NUM_DESC+k)*ADDR_W +: ADDR_W];
                        w_dst   = desc_dst_i[(c*NUM_DESC+k)*ADDR_W +: ADDR_W];
                        w_bytes = desc_bytes_i[(c*NUM_DESC+k)*BYTES_W +: BYTES_W];
                    end
                end
            end
        end
    end

    assign w_run_abort = |(w_running & ch_abort_i);
    assign w_run_more  = |(w_running & w_has_more);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st    <= S_IDLE;
            r_run   <= '0;
            r_req   <= '0;
            r_valid <= 1'b0;
            r_abort <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_bytes <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_ch_st[c] <= CH_IDLE;
                r_didx[c]  <= '0;
            end
        end else begin
            r_req <= w_pend;
            for (int c = 0; c < NUM_CH; c++) begin
                case (r_ch_st[c])
                    CH_IDLE: if (ch_go_i[c] && !ch_abort_i[c]) begin
                        r_ch_st[c] <= CH_PEND;
                        r_didx[c]  <= '0;
                    end
                    CH_PEND: if (ch_abort_i[c] && !w_running[c]) r_ch_st[c] <= CH_ERR;
                    default: if (ch_clear_i[c]) r_ch_st[c] <= CH_IDLE;
                endcase
            end
            case (r_st)
                S_IDLE: if (w_accept) begin
                    if (w_found) begin
                        r_run          <= w_gch;
                        r_src          <= w_src;
                        r_dst          <= w_dst;
                        r_bytes        <= w_bytes;
                        r_didx[w_gch]  <= w_dnext;
                        r_valid        <= 1'b1;
                        r_st           <= S_ISSUE;
                    end else begin
                        r_ch_st[w_gch] <= CH_DONE;
                    end
                end
                S_ISSUE: begin
                    if (w_run_abort) r_abort <= 1'b1;
                    if (sif.sched_ready_i) begin
                        r_valid <= 1'b0;
                        r_st    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_run_abort) r_abort <= 1'b1;
                    if (sif.job_done_i || sif.job_err_i) begin
                        r_st    <= S_IDLE;
                        r_abort <= 1'b0;
                        if (sif.job_err_i || r_abort || w_run_abort) r_ch_st[r_run] <= CH_ERR;
                        else if (!w_run_more)                        r_ch_st[r_run] <= CH_DONE;
                    end
                end
                default: r_st <= S_IDLE;
            endcase
        end
    end

    assign sif.sched_valid_o = r_valid;
    assign sif.sched_ch_o    = r_run;
    assign sif.sched_src_o   = r_src;
    assign sif.sched_dst_o   = r_dst;
    assign sif.sched_bytes_o = r_bytes;
    assign sif.job_abort_o   = r_abort;

endmodule

// File: doc/dma_mch_sched.md
DMA_MCH_SCHED -- requirements
Module: dma_mch_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent DMA channels, 1..16.
REQ-002 SHALL have parameter NUM_DESC, default 2: descriptors per channel, 1..8.
REQ-003 SHALL have parameter ADDR_W, default 32: address width.
REQ-004 SHALL have parameter BYTES_W, default 32: byte-count width.
REQ-005 SHALL have port clk  in  1  single clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ch_go_i  in  NUM_CH  one-cycle start pulse per channel.
REQ-008 SHALL have port ch_abort_i  in  NUM_CH  one-cycle abort pulse per channel.
REQ-009 SHALL have port ch_clear_i  in  NUM_CH  one-cycle status-clear pulse per channel.
REQ-010 SHALL have port desc_en_i  in  NUM_CH*NUM_DESC  descriptor enable.
REQ-011 SHALL have ports desc_src_i / desc_dst_i  in  NUM_CH*NUM_DESC*ADDR_W  source/destination addresses.
REQ-012 SHALL have port desc_bytes_i  in  NUM_CH*NUM_DESC*BYTES_W  transfer length in bytes.
REQ-013 SHALL have port sched_valid_o  out  1  job offered to the streamer pair.
REQ-014 SHALL have port sched_ready_i  in  1  streamer accepts job.
REQ-015 SHALL have ports sched_ch_o  out  $clog2(NUM_CH) (min 1), sched_src_o / sched_dst_o  out  ADDR_W, sched_bytes_o  out  BYTES_W: job fields.
REQ-016 SHALL have ports job_done_i / job_err_i  in  1  job completion / error pulses.
REQ-017 SHALL have port job_abort_o  out  1  abort request for the running job.
REQ-018 SHALL have ports ch_busy_o, ch_done_o, ch_err_o  out  NUM_CH  per-channel status.

Function
REQ-019 Each channel SHALL hold state IDLE, PEND, DONE or ERR; RUN is exposed via ch_busy_o; at most one channel runs at a time.
REQ-020 ch_go_i in IDLE SHALL set PEND and descriptor index 0 on the next edge; go in any other state SHALL be ignored.
REQ-021 Scheduler FSM SHALL have states S_IDLE, S_ISSUE, S_WAIT: S_IDLE grants one PEND channel round-robin (priority starting after the last grantee); S_ISSUE holds sched_valid_o and stable fields until sched_ready_i; S_WAIT waits for job_done_i/job_err_i, then returns to S_IDLE.
REQ-022 Each grant SHALL issue exactly one descriptor, after which arbitration moves to the next PEND channel (descriptor-level fairness).
REQ-023 Descriptors with desc_en_i=0 or bytes=0 SHALL be skipped without issue; a PEND channel with no remaining valid descriptor SHALL go to DONE on its grant.
REQ-024 After the job for its last valid descriptor completes, a channel SHALL go to DONE (ch_done_o=1).
REQ-025 job_err_i SHALL send the running channel to ERR; job_done_i and job_err_i in the same cycle SHALL be treated as error.
REQ-026 ch_abort_i on a PEND channel SHALL send it to ERR immediately.
REQ-027 ch_abort_i on the running channel SHALL assert job_abort_o until completion, with the channel ending in ERR.
REQ-028 Abort and go in the same cycle SHALL honour the abort only.
REQ-029 ch_clear_i SHALL return DONE/ERR to IDLE and SHALL be ignored in other states.
REQ-030 Latency: go at edge N SHALL give sched_valid_o high at N+2 earliest when the scheduler is idle.
REQ-031 ch_busy_o SHALL be 1 in PEND and RUN.

Reset
REQ-032 Asserting rst SHALL immediately set all channels to IDLE, the FSM to S_IDLE, the RR pointer to 0, and all outputs to 0, aborting any in-flight job without job_abort_o.
REQ-033 After rst deasserts, the first grant SHALL favour channel 0.

Structure
REQ-034 The channel-state and scheduler-state enums and the NUM_CH / NUM_DESC defaults SHALL live in dma_utils_pkg.
REQ-035 Round-robin selection SHALL be a sub-module dma_rr_arbiter (req vector in, one-hot grant out, pointer update on an accept strobe).

Verification
REQ-036 Reset then go ch0 with desc0 = 0x1000->0x2000, 64 B and desc1 enabled -> two jobs issued, ch_done_o[0]=1 after the second job_done_i.
REQ-037 ch0 and ch2 go in the same cycle, each with 2 descs -> issue order ch0d0, ch2d0, ch0d1, ch2d1.
REQ-038 desc0 bytes=0 and desc1 disabled -> no sched_valid_o, ch_done_o=1 within 3 cycles.
REQ-039 ch1 running, ch_abort_i[1] pulse -> job_abort_o held until job_done_i, then ch_err_o[1]=1; ch_clear_i -> IDLE.
REQ-040 job_done_i and job_err_i together -> ch_err_o=1; rst asserted in S_ISSUE -> sched_valid_o=0 immediately.
